// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and constants for the significand multiplier
package fpu_pkg;

    localparam int FP16_FRACW = 10;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    // Number of iterations needed to retire all multiplier bits.
    function automatic int mul_iters(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/fpu_seq_multiplier_if.sv
// rtl/fpu_seq_multiplier_if.sv - operand/product handshake bundle for fpu_seq_multiplier
interface fpu_seq_multiplier_if #(
    parameter int WIDTH = 11
);
    logic                   inValid;
    logic                   inReady;
    logic                   isSigned;
    logic [WIDTH-1:0]       mulIn1;
    logic [WIDTH-1:0]       mulIn2;
    logic                   outValid;
    logic                   outReady;
    logic [2*WIDTH-1:0]     mulOut;

    modport master (
        output inValid, isSigned, mulIn1, mulIn2, outReady,
        input  inReady, outValid, mulOut
    );

    modport slave (
        input  inValid, isSigned, mulIn1, mulIn2, outReady,
        output inReady, outValid, mulOut
    );
endinterface

// File: rtl/fpu_mul_partial.sv
// rtl/fpu_mul_partial.sv - combinational magnitude x BPC-bit digit partial product
module fpu_mul_partial #(
    parameter int WIDTH = 11,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0]     mag_i,
    input  logic [BPC-1:0]       digit_i,
    output logic [WIDTH+BPC-1:0] partial_o
);
    assign partial_o = {{BPC{1'b0}}, mag_i} * {{WIDTH{1'b0}}, digit_i};
endmodule

// File: rtl/fpu_seq_multiplier.sv
// rtl/fpu_seq_multiplier.sv - sequential radix-2^BPC shift-add significand multiplier
module fpu_seq_multiplier
    import fpu_pkg::*;
#(
    parameter int WIDTH = FP16_FRACW + 1,
    parameter int BPC   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    fpu_seq_multiplier_if.slave   bus
);
    localparam int N  = mul_iters(WIDTH, BPC);
    localparam int CW = $clog2(N) + 1;
    localparam int AW = 2 * WIDTH;
    localparam int PW = WIDTH + BPC;

    if ((WIDTH % BPC) != 0) begin : g_bad_bpc
        $error("fpu_seq_multiplier: BPC must divide WIDTH");
    end

    mul_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mag1_q, mag1_d;
    logic [WIDTH-1:0] mul_q, mul_d;
    logic             sign_q, sign_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    out_q, out_d;
    logic [PW-1:0]    partial;
    logic [AW-1:0]    acc_sum;

    fpu_mul_partial #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_partial (
        .mag_i     (mag1_q),
        .digit_i   (mul_q[BPC-1:0]),
        .partial_o (partial)
    );

    assign acc_sum = acc_q + (AW'(partial) << (int'(cnt_q) * BPC));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag1_d  = mag1_q;
        mul_d   = mul_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        out_d   = out_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (bus.inValid) begin
                    state_d = MUL_BUSY;
                    mag1_d  = (bus.isSigned && bus.mulIn1[WIDTH-1]) ? -bus.mulIn1 : bus.mulIn1;
                    mul_d   = (bus.isSigned && bus.mulIn2[WIDTH-1]) ? -bus.mulIn2 : bus.mulIn2;
                    sign_d  = bus.isSigned & (bus.mulIn1[WIDTH-1] ^ bus.mulIn2[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            MUL_BUSY: begin
                acc_d = acc_sum;
                mul_d = mul_q >> BPC;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = MUL_DONE;
                    cnt_d   = '0;
                    out_d   = sign_q ? -acc_sum : acc_sum;
                end
            end
            MUL_DONE: begin
                if (bus.outReady) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
        // Flush wins over any accept or completion in the same cycle and keeps the last product.
        if (flush) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            mag1_q  <= '0;
            mul_q   <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag1_q  <= mag1_d;
            mul_q   <= mul_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.inReady  = (state_q == MUL_IDLE);
    assign bus.outValid = (state_q == MUL_DONE);
    assign bus.mulOut   = out_q;

endmodule
